// File: rtl/alu_cmd_seq.sv
// rtl/alu_cmd_seq.sv - command FIFO, credit-limited issue and response buffer around a 1-cycle registered ALU
// Define ALU_CMD_ILLEGAL_CHK_EN to flag opcode 3'b111 on rsp_err.
module alu_cmd_seq #(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        res,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [11:0] alu_oper,
  input  logic [7:0]  alu_sum,
  input  logic        alu_c_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_sum,
  output logic        rsp_c_out,
  output logic        rsp_err
);
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);

  logic [18:0]    cmd_mem_q [CMD_DEPTH];
  logic [CAW-1:0] cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
  logic [CAW:0]   cmd_cnt_q, cmd_cnt_d;

  logic [9:0]     rsp_mem_q [RSP_DEPTH];
  logic [RAW-1:0] rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
  logic [RAW:0]   rsp_cnt_q, rsp_cnt_d;

  logic           s1_q, s2_q, err1_q, err2_q;
  logic [7:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]     alu_op_q, alu_op_d;

  logic           cmd_push, issue, rsp_pop, issue_err;
  logic [18:0]    cmd_head;
  logic [9:0]     rsp_head;
  logic [RAW+1:0] credits_used;

  assign cmd_head  = cmd_mem_q[cmd_rd_q];
  assign rsp_head  = rsp_mem_q[rsp_rd_q];
  assign cmd_ready = (cmd_cnt_q != (CAW+1)'(CMD_DEPTH));
  assign cmd_push  = cmd_valid && cmd_ready;

  // Every issued command owns a response slot until popped, so the buffer can never overflow.
  assign credits_used = (RAW+2)'(s1_q) + (RAW+2)'(s2_q) + (RAW+2)'(rsp_cnt_q);
  assign issue        = (cmd_cnt_q != '0) && (credits_used < (RAW+2)'(RSP_DEPTH));

  assign rsp_valid = (rsp_cnt_q != '0);
  assign rsp_pop   = rsp_valid && rsp_ready;

`ifdef ALU_CMD_ILLEGAL_CHK_EN
  assign issue_err = (cmd_head[2:0] == 3'b111);
`else
  assign issue_err = 1'b0;
`endif

  always_comb begin
    cmd_wr_d  = cmd_wr_q + CAW'(cmd_push);
    cmd_rd_d  = cmd_rd_q + CAW'(issue);
    cmd_cnt_d = cmd_cnt_q + (CAW+1)'(cmd_push) - (CAW+1)'(issue);
    rsp_wr_d  = rsp_wr_q + RAW'(s2_q);
    rsp_rd_d  = rsp_rd_q + RAW'(rsp_pop);
    rsp_cnt_d = rsp_cnt_q + (RAW+1)'(s2_q) - (RAW+1)'(rsp_pop);
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    if (issue) begin
      alu_a_d  = cmd_head[18:11];
      alu_b_d  = cmd_head[10:3];
      alu_op_d = cmd_head[2:0];
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cmd_wr_q  <= '0;
      cmd_rd_q  <= '0;
      cmd_cnt_q <= '0;
      rsp_wr_q  <= '0;
      rsp_rd_q  <= '0;
      rsp_cnt_q <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      err1_q    <= 1'b0;
      err2_q    <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
    end else begin
      cmd_wr_q  <= cmd_wr_d;
      cmd_rd_q  <= cmd_rd_d;
      cmd_cnt_q <= cmd_cnt_d;
      rsp_wr_q  <= rsp_wr_d;
      rsp_rd_q  <= rsp_rd_d;
      rsp_cnt_q <= rsp_cnt_d;
      s1_q      <= issue;
      s2_q      <= s1_q;
      err1_q    <= issue && issue_err;
      err2_q    <= err1_q;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
    end
  end

  // Storage arrays need no reset: reads are masked by the counts.
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem_q[cmd_wr_q] <= {cmd_a, cmd_b, cmd_op};
    if (s2_q)     rsp_mem_q[rsp_wr_q] <= {alu_sum, alu_c_out, err2_q};
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_oper  = {9'b0, alu_op_q};
  assign rsp_sum   = rsp_valid ? rsp_head[9:2] : 8'h00;
  assign rsp_c_out = rsp_valid & rsp_head[1];
  assign rsp_err   = rsp_valid & rsp_head[0];

endmodule

// File: doc/alu_cmd_seq.md
Name: alu_cmd_seq

Overview:
- Command sequencer directly upstream of the 8-bit registered ALU (opcodes Add=0, Substract=1, Substract_a=2, Or=3, And=4, Xor=5, Xnor=6).
- Buffers operand/opcode commands from a valid/ready producer and issues at most one per cycle to the ALU's a/b/oper inputs.
- Tracks the ALU's one-cycle registered latency and captures sum/c_out into a response buffer.
- Delivers responses in order on a valid/ready consumer port.

Parameters:
- CMD_DEPTH, 4, command FIFO entries; power of 2, at least 2.
- RSP_DEPTH, 4, response buffer entries; power of 2, at least 2; also the issue credit limit.

Ports:
- clk  in  1  sole clock, rising edge.
- res  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command FIFO can accept.
- cmd_a  in  8  operand a.
- cmd_b  in  8  operand b.
- cmd_op  in  3  opcode.
- alu_a  out  8  registered, to ALU a.
- alu_b  out  8  registered, to ALU b.
- alu_oper  out  12  registered, to ALU oper; {9'b0, op}.
- alu_sum  in  8  ALU sum.
- alu_c_out  in  1  ALU c_out.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts.
- rsp_sum  out  8  result.
- rsp_c_out  out  1  carry (Add only; 0 otherwise).
- rsp_err  out  1  illegal-opcode flag; 0 when feature compiled out.

Behaviour:
- Interface: one clock (clk); reset res is asynchronous, active-low. All state is cleared on res low, independent of clk.
- Reset values:
  - cmd_ready=1, rsp_valid=0, rsp_sum=0, rsp_c_out=0, rsp_err=0.
  - alu_a=0, alu_b=0, alu_oper=0.
  - FIFOs empty; pipeline flags s1=s2=0.
- Accept: on the edge where cmd_valid&&cmd_ready, push {a,b,op}.
  - cmd_ready = !cmd_full. Registered from count; no same-cycle pop bypass when full.
- Issue:
  - Condition: FIFO non-empty && (s1+s2+rsp_count) < RSP_DEPTH. rsp_count uses the pre-edge value.
  - On an issue edge: pop the FIFO, load alu_a/alu_b/alu_oper, set s1=1. Otherwise s1=0.
  - alu_* registers hold their last value when not issuing.
- Latency tracking:
  - s2 <= s1 every edge. The ALU registers its result at the edge after issue.
  - When s2=1, push {alu_sum, alu_c_out, err} into the response buffer at the next edge.
  - Credit rule guarantees this push never overflows.
- Latency: command accepted at edge E into an empty system, rsp_ready=1 → issue edge E+1, rsp_valid high after edge E+3.
- Throughput: 1 command/cycle sustained while rsp_ready=1.
- Response port:
  - rsp_* reflect the buffer head; pop on rsp_valid&&rsp_ready.
  - Simultaneous push and pop keeps the count unchanged.
  - rsp_valid is held stable with unchanged data until accepted.
- Ordering: strictly FIFO, end to end.
- Full/empty:
  - A full command FIFO drops cmd_ready.
  - A response buffer plus in-flight credits at RSP_DEPTH stalls issue; no ALU command is lost.
- Simultaneous push and pop on a full command FIFO: pop occurs; push is blocked because cmd_ready=0.
- Pointer arithmetic: log2(depth) bits with natural wrap; count is log2(depth)+1 bits.
- Reset mid-operation: all buffered and in-flight commands are discarded. alu_* return to 0, so the ALU sees oper=Add with a=b=0.

Optional Feature:
- Macro: ALU_CMD_ILLEGAL_CHK_EN.
- Defined:
  - cmd_op=3'b111 is still accepted and issued unchanged; the ALU default returns sum=0, c_out=0.
  - An err bit travels with the command through s1/s2 and appears as rsp_err=1 on that response only.
- Undefined: no err tracking; rsp_err is tied to 0. Opcode 7 gets an ordinary response of sum=0, c_out=0.

Test Plan:
- Reset then single Add, a=8'hFF, b=8'hA1, rsp_ready=1 → 3 cycles after accept: rsp_valid=1, rsp_sum=8'hA0, rsp_c_out=1, rsp_err=0.
- Back-to-back Xor (8'h04, 8'h09), Xnor (8'h06, 8'h61), And (8'h60, 8'h21) → in-order responses 8'h0D, 8'h98, 8'h20, all c_out=0, on consecutive cycles.
- Hold rsp_ready=0 and stream 10 commands:
  - exactly RSP_DEPTH responses buffer;
  - cmd_ready falls after CMD_DEPTH further accepts;
  - releasing rsp_ready yields all 10 in order (Substract 8'h03-8'h05 → 8'hFE; Substract_a same operands → 8'h02).
- Assert res low with 3 commands in flight → outputs take reset values immediately (asynchronous). After release, no stale rsp_valid, and a new Or 8'h03|8'h05 returns 8'h07.
- Toggle rsp_ready randomly every cycle during 20 mixed ops → no drop, no duplicate, and rsp_* stable while rsp_valid&&!rsp_ready.
- Opcode 3'b111, a=8'h12, b=8'h34 → rsp_sum=0, rsp_c_out=0, rsp_err=1 with ALU_CMD_ILLEGAL_CHK_EN defined; rsp_err=0 without it.
